// File: rtl/adder_fault_pkg.sv
// adder_fault_pkg: fault_mode encodings and FSM state constants shared by the adder and its cells
package adder_fault_pkg;
  localparam logic [1:0] FM_SA0  = 2'd0;
  localparam logic [1:0] FM_SA1  = 2'd1;
  localparam logic [1:0] FM_SINV = 2'd2;
  localparam logic [1:0] FM_CINV = 2'd3;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/fault_fa_cell.sv
// fault_fa_cell: full adder whose sum or carry-out can be corrupted when fault_hit is set
//   a, b, cin   addend bits and carry-in
//   fault_hit   this cell is the targeted one
//   fault_mode  sum stuck-at-0 / stuck-at-1 / inverted, or carry-out inverted
//   sum, cout   possibly faulted outputs
module fault_fa_cell
  import adder_fault_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       fault_hit,
  input  logic [1:0] fault_mode,
  output logic       sum,
  output logic       cout
);
  logic s_raw;
  assign s_raw = a ^ b ^ cin;
  assign sum = !fault_hit ? s_raw :
               fault_mode == FM_SA0  ? 1'b0 :
               fault_mode == FM_SA1  ? 1'b1 :
               fault_mode == FM_SINV ? ~s_raw : s_raw;
  assign cout = ((a & b) | (cin & (a ^ b))) ^ (fault_hit && fault_mode == FM_CINV);
endmodule

// File: rtl/fault_inj_digit_serial_adder.sv
// fault_inj_digit_serial_adder: digit-serial A+B+CIN with one injectable faulty cell and a golden check
//   in_valid/in_ready    operand + fault config handshake (accepted in IDLE only)
//   a, b, cin            operands and carry-in
//   fault_en/pos/mode    fault config captured at accept
//   out_valid/out_ready  result handshake
//   sum, golden          faulted and fault-free WIDTH+1 bit results
//   mismatch             sum != golden while out_valid
//   err_count            saturating count of accepted mismatching results
module fault_inj_digit_serial_adder
  import adder_fault_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  input  logic                   fault_en,
  input  logic [$clog2(WIDTH):0] fault_pos,
  input  logic [1:0]             fault_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH:0]         sum,
  output logic [WIDTH:0]         golden,
  output logic                   mismatch,
  output logic [CNTW-1:0]        err_count
);
  localparam int ND = WIDTH / DIGIT;
  localparam int IW = ND > 1 ? $clog2(ND) : 1;
  localparam logic [IW-1:0] LAST = IW'(ND - 1);
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end
  state_t                 state;
  logic [WIDTH-1:0]       a_q, b_q;
  logic                   carry_q;
  logic [IW-1:0]          idx;
  logic                   fe_q;
  logic [$clog2(WIDTH):0] fp_q;
  logic [1:0]             fm_q;
  logic [DIGIT:0]         c;
  logic [DIGIT-1:0]       s;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign mismatch  = out_valid && sum != golden;
  assign c[0]      = carry_q;
  // Operands shift right one digit per cycle, so the chain always reads the low DIGIT bits.
  for (genvar k = 0; k < DIGIT; k++) begin : g_cell
    fault_fa_cell u_cell (
      .a          (a_q[k]),
      .b          (b_q[k]),
      .cin        (c[k]),
      .fault_hit  (fe_q && int'(fp_q) == int'(idx) * DIGIT + k),
      .fault_mode (fm_q),
      .sum        (s[k]),
      .cout       (c[k+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      fe_q      <= 1'b0;
      fp_q      <= '0;
      fm_q      <= '0;
      sum       <= '0;
      golden    <= '0;
      err_count <= '0;
    end else if (state == S_IDLE && in_valid) begin
      state   <= S_RUN;
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
      fe_q    <= fault_en;
      fp_q    <= fault_pos;
      fm_q    <= fault_mode;
      golden  <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end else if (state == S_RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= c[DIGIT];
      idx     <= idx + 1'b1;
      // Result digits enter at the top; after ND cycles digit 0 sits at bit 0.
      sum[WIDTH-1:0] <= WIDTH'({s, sum[WIDTH-1:0]} >> DIGIT);
      if (idx == LAST) begin
        sum[WIDTH] <= c[DIGIT];
        state      <= S_DONE;
      end
    end else if (state == S_DONE && out_ready) begin
      state <= S_IDLE;
      if (mismatch && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fault_inj_digit_serial_adder.sv
// tb_fault_inj_digit_serial_adder: directed and random checks against an arithmetic fault model
module tb_fault_inj_digit_serial_adder;
  localparam int W = 8;
  localparam int D = 2;
  localparam int ND = W / D;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, cin = 0, fault_en = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [$clog2(W):0] fault_pos = 0;
  logic [1:0] fault_mode = 0;
  logic out_valid, out_ready = 0, mismatch;
  logic [W:0] sum, golden;
  logic [15:0] err_count;
  int checks = 0, errors = 0, exp_err = 0;
  always #5 clk = ~clk;
  fault_inj_digit_serial_adder #(.WIDTH(W), .DIGIT(D), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .fault_en(fault_en), .fault_pos(fault_pos),
    .fault_mode(fault_mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .golden(golden), .mismatch(mismatch), .err_count(err_count)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  // Ripple below the faulty bit is plain addition; the faulty bit is evaluated alone; the rest adds its carry.
  function automatic int model(int xa, int xb, int xc, int fe, int fp, int fm);
    int mask, lo, t, sb, co, hi;
    if (fe == 0 || fp >= W) return xa + xb + xc;
    mask = (1 << fp) - 1;
    lo = (xa & mask) + (xb & mask) + xc;
    t = ((xa >> fp) & 1) + ((xb >> fp) & 1) + (lo >> fp);
    sb = t & 1;
    co = t >> 1;
    if (fm == 0) sb = 0;
    else if (fm == 1) sb = 1;
    else if (fm == 2) sb = sb ^ 1;
    else co = co ^ 1;
    hi = (xa >> (fp + 1)) + (xb >> (fp + 1)) + co;
    return (lo & mask) | (sb << fp) | (hi << (fp + 1));
  endfunction
  task automatic run_op(input int xa, input int xb, input int xc, input int fe, input int fp, input int fm, input int hold);
    int es, eg, n;
    es = model(xa, xb, xc, fe, fp, fm);
    eg = xa + xb + xc;
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1; a = W'(xa); b = W'(xb); cin = xc[0];
    fault_en = fe[0]; fault_pos = fp[$clog2(W):0]; fault_mode = fm[1:0];
    @(negedge clk);
    in_valid = 0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    fault_en = 1'($urandom); fault_pos = 4'($urandom); fault_mode = 2'($urandom);
    chk("in_ready_run", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("latency", n, ND);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("out_valid", int'(out_valid), 1);
      chk("in_ready_done", int'(in_ready), 0);
      chk("sum", int'(sum), es);
      chk("golden", int'(golden), eg);
      chk("mismatch", int'(mismatch), int'(es != eg));
      chk("err_hold", int'(err_count), exp_err);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    if (es != eg) exp_err++;
    chk("out_valid_clr", int'(out_valid), 0);
    chk("err_count", int'(err_count), exp_err);
  endtask
  initial begin
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_golden", int'(golden), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_err", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1;
    run_op(100, 27, 0, 0, 0, 0, 0);
    run_op(0, 0, 0, 1, 6, 3, 0);
    run_op(2, 2, 0, 1, 0, 1, 0);
    run_op(255, 255, 1, 1, 9, 2, 0);
    run_op(0, 0, 0, 1, 7, 3, 3);
    run_op(85, 170, 1, 1, 1, 3, 3);
    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    in_valid = 1; a = 8'd200; b = 8'd100; cin = 1; fault_en = 1; fault_pos = 2; fault_mode = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_err", int'(err_count), 0);
    exp_err = 0;
    @(negedge clk);
    rst_n = 1;
    run_op(200, 100, 1, 0, 2, 0, 0);
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)),
             int'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(3)),
             int'($urandom_range(2)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
